// File: rtl/apb_timer_csr_if.sv
// APB slave bus bundle for the timer CSR block.
interface apb_timer_csr_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_csr.sv
// APB register block with NUM_CH down-counting timers, W1C interrupt status
// and per-channel interrupt enables. Zero-wait-state, combinational read path.
module apb_timer_csr #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hDEADBEEF
) (
  input  logic              pclk,
  input  logic              hrst,
  apb_timer_csr_if.slave    apb,
  output logic [NUM_CH-1:0] irq
);

  localparam logic [ADDR_WIDTH-1:0] A_ID       = ADDR_WIDTH'(32'h000);
  localparam logic [ADDR_WIDTH-1:0] A_INT_EN   = ADDR_WIDTH'(32'h004);
  localparam logic [ADDR_WIDTH-1:0] A_INT_STAT = ADDR_WIDTH'(32'h008);

  function automatic logic [ADDR_WIDTH-1:0] ch_addr(input int unsigned c, input int unsigned off);
    return ADDR_WIDTH'(32'h100 + 32'h10 * c + off);
  endfunction

  logic [NUM_CH-1:0]    r_int_en;
  logic [NUM_CH-1:0]    r_int_stat;
  logic [NUM_CH-1:0]    r_en;
  logic [NUM_CH-1:0]    r_mode;
  logic [CNT_WIDTH-1:0] r_load  [NUM_CH];
  logic [CNT_WIDTH-1:0] r_count [NUM_CH];

  logic                 w_access, w_rd, w_err, w_wr_ok, w_mapped, w_ro;
  logic                 w_hit_id, w_hit_en, w_hit_stat;
  logic [NUM_CH-1:0]    w_hit_ctrl, w_hit_load, w_hit_count;
  logic [NUM_CH-1:0]    w_start, w_expire, w_stat_clr;
  logic [NUM_CH-1:0]    w_int_en_nxt, w_stat_nxt, w_en_nxt, w_mode_nxt;
  logic [CNT_WIDTH-1:0] w_load_nxt  [NUM_CH];
  logic [CNT_WIDTH-1:0] w_count_nxt [NUM_CH];
  logic [31:0]          w_rdata;
  logic                 w_unused;

  // Address decode and error classification
  always_comb begin
    w_hit_id    = (apb.paddr == A_ID);
    w_hit_en    = (apb.paddr == A_INT_EN);
    w_hit_stat  = (apb.paddr == A_INT_STAT);
    w_hit_ctrl  = '0;
    w_hit_load  = '0;
    w_hit_count = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_hit_ctrl[c]  = (apb.paddr == ch_addr(c, 0));
      w_hit_load[c]  = (apb.paddr == ch_addr(c, 4));
      w_hit_count[c] = (apb.paddr == ch_addr(c, 8));
    end
    w_mapped = w_hit_id | w_hit_en | w_hit_stat | (|w_hit_ctrl) | (|w_hit_load) | (|w_hit_count);
    w_ro     = w_hit_id | (|w_hit_count);
    w_access = apb.psel & apb.penable;
    w_rd     = w_access & ~apb.pwrite;
    w_err    = w_access & (~w_mapped | (apb.pwrite & w_ro));
    w_wr_ok  = w_access & apb.pwrite & w_mapped & ~w_ro;
  end

  // Read mux; unmapped addresses fall through to zero
  always_comb begin
    w_rdata = '0;
    if (w_hit_id)   w_rdata = ID_VALUE;
    if (w_hit_en)   w_rdata = 32'(r_int_en);
    if (w_hit_stat) w_rdata = 32'(r_int_stat);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_hit_ctrl[c])  w_rdata = 32'({r_mode[c], r_en[c]});
      if (w_hit_load[c])  w_rdata = 32'(r_load[c]);
      if (w_hit_count[c]) w_rdata = 32'(r_count[c]);
    end
  end

  assign apb.prdata  = (w_rd & ~hrst) ? w_rdata : 32'h0;
  assign apb.pslverr = w_err & ~hrst;
  assign apb.pready  = 1'b1;
  assign irq         = r_int_stat & r_int_en;
  assign w_unused    = ^apb.pwdata;

  // Next-state: START beats expiry, expiry beats plain decrement; set beats W1C
  always_comb begin
    w_int_en_nxt = r_int_en;
    w_en_nxt     = r_en;
    w_mode_nxt   = r_mode;
    w_load_nxt   = r_load;
    w_count_nxt  = r_count;
    w_start      = '0;
    w_expire     = '0;
    w_stat_clr   = '0;
    if (w_wr_ok && w_hit_en)   w_int_en_nxt = apb.pwdata[NUM_CH-1:0];
    if (w_wr_ok && w_hit_stat) w_stat_clr   = apb.pwdata[NUM_CH-1:0];
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_wr_ok && w_hit_load[c]) w_load_nxt[c] = apb.pwdata[CNT_WIDTH-1:0];
      if (w_wr_ok && w_hit_ctrl[c]) begin
        w_en_nxt[c]   = apb.pwdata[0];
        w_mode_nxt[c] = apb.pwdata[1];
        w_start[c]    = apb.pwdata[2];
      end
      w_expire[c] = r_en[c] && (r_count[c] == CNT_WIDTH'(1));
      if (w_start[c])
        w_count_nxt[c] = w_load_nxt[c];
      else if (w_expire[c])
        w_count_nxt[c] = r_mode[c] ? r_load[c] : '0;
      else if (r_en[c] && (r_count[c] != '0))
        w_count_nxt[c] = r_count[c] - CNT_WIDTH'(1);
    end
    w_stat_nxt = (r_int_stat & ~w_stat_clr) | w_expire;
  end

  always_ff @(posedge pclk or posedge hrst) begin
    if (hrst) begin
      r_int_en   <= '0;
      r_int_stat <= '0;
      r_en       <= '0;
      r_mode     <= '0;
      r_load     <= '{default: '0};
      r_count    <= '{default: '0};
    end else begin
      r_int_en   <= w_int_en_nxt;
      r_int_stat <= w_stat_nxt;
      r_en       <= w_en_nxt;
      r_mode     <= w_mode_nxt;
      r_load     <= w_load_nxt;
      r_count    <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_apb_timer_csr.sv
// Directed bench for apb_timer_csr: register-access vector table plus
// hand-timed countdown, periodic, pause, and reset sequences.
module tb_apb_timer_csr;

  localparam int unsigned NUM_CH = 4;

  logic              pclk;
  logic              hrst;
  logic [NUM_CH-1:0] irq;
  int                n_checks;
  int                n_err;

  apb_timer_csr_if #(.ADDR_WIDTH(32)) bus ();

  apb_timer_csr #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(16), .ADDR_WIDTH(32), .ID_VALUE(32'hDEADBEEF)
  ) dut (
    .pclk(pclk), .hrst(hrst), .apb(bus), .irq(irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full APB transfer; entered and left just after a rising edge
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(negedge pclk);
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    logic        e;
    xfer(1'b1, addr, wdata, d, e);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    xfer(1'b0, addr, 32'h0, d, e);
    check(name, d, exp);
  endtask

  // Held read access phase so a register can be observed every cycle
  task automatic stream_open(input logic [31:0] addr);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
  endtask

  task automatic stream_close();
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] exp_cnt [6];
    logic [3:0]  exp_irq [6];

    n_checks = 0;
    n_err    = 0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    vecs[0]  = '{1'b0, 32'h000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h000, 32'h12345678, 32'h0,        1'b1};
    vecs[2]  = '{1'b0, 32'h000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h004, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h004, 32'h0,        32'h0000000F, 1'b0};
    vecs[5]  = '{1'b1, 32'h104, 32'h00012345, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h104, 32'h0,        32'h00002345, 1'b0};
    vecs[7]  = '{1'b1, 32'h108, 32'h00000055, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h108, 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h134, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h130, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h130, 32'h0,        32'h00000003, 1'b0};
    vecs[12] = '{1'b0, 32'h138, 32'h0,        32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h008, 32'h0,        32'h0,        1'b0};
    vecs[14] = '{1'b1, 32'h140, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h140, 32'h0,        32'h0,        1'b1};
    vecs[16] = '{1'b0, 32'h148, 32'h0,        32'h0,        1'b1};
    vecs[17] = '{1'b0, 32'h00C, 32'h0,        32'h0,        1'b1};
    vecs[18] = '{1'b0, 32'h10C, 32'h0,        32'h0,        1'b1};
    vecs[19] = '{1'b0, 32'h002, 32'h0,        32'h0,        1'b1};
    vecs[20] = '{1'b1, 32'h008, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[21] = '{1'b0, 32'h004, 32'h0,        32'h0000000F, 1'b0};
    vecs[22] = '{1'b1, 32'h004, 32'h0,        32'h0,        1'b0};
    vecs[23] = '{1'b1, 32'h130, 32'h0,        32'h0,        1'b0};

    // Reset state
    hrst = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset irq", 32'(irq), 32'h0);
    check("reset prdata", bus.prdata, 32'h0);
    check("reset pready", 32'(bus.pready), 32'h1);
    @(posedge pclk); #1;
    hrst = 1'b0;
    @(posedge pclk); #1;

    // Register access table
    for (int i = 0; i < 24; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e);
      check($sformatf("vec%0d prdata", i), d, vecs[i].exp_rdata);
      check($sformatf("vec%0d pslverr", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // ch0 one-shot countdown from 5 with irq
    wr(32'h104, 32'd5);
    wr(32'h004, 32'h1);
    wr(32'h100, 32'h5);
    exp_cnt = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    exp_irq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
    stream_open(32'h108);
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      check($sformatf("oneshot count[%0d]", i), bus.prdata, exp_cnt[i]);
      check($sformatf("oneshot irq[%0d]", i), 32'(irq), 32'(exp_irq[i]));
    end
    stream_close();
    rd_check("oneshot int_stat", 32'h008, 32'h1);
    wr(32'h008, 32'h1);
    rd_check("w1c int_stat", 32'h008, 32'h0);

    // ch1 periodic LOAD=3, then W1C landing on an expiry edge
    wr(32'h114, 32'd3);
    wr(32'h110, 32'h7);
    exp_cnt = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3};
    stream_open(32'h118);
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      check($sformatf("periodic count[%0d]", i), bus.prdata, exp_cnt[i]);
    end
    stream_close();
    wr(32'h008, 32'h2);
    rd_check("set beats w1c", 32'h008, 32'h2);
    wr(32'h110, 32'h0);
    wr(32'h008, 32'h2);
    rd_check("periodic cleared", 32'h008, 32'h0);

    // ch2 paused at 7, then resumed
    wr(32'h124, 32'd10);
    wr(32'h120, 32'h5);
    @(posedge pclk); #1;
    wr(32'h120, 32'h0);
    rd_check("pause count", 32'h128, 32'd7);
    rd_check("pause hold", 32'h128, 32'd7);
    wr(32'h120, 32'h1);
    exp_cnt = '{32'd6, 32'd5, 32'd4, 32'd0, 32'd0, 32'd0};
    stream_open(32'h128);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("resume count[%0d]", i), bus.prdata, exp_cnt[i]);
    end
    stream_close();
    wr(32'h120, 32'h0);

    // Reset while ch0 is at 2
    wr(32'h004, 32'h1);
    wr(32'h104, 32'd4);
    wr(32'h100, 32'h5);
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    hrst = 1'b1;
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'h000;
    @(negedge pclk);
    check("rst prdata", bus.prdata, 32'h0);
    check("rst pslverr", 32'(bus.pslverr), 32'h0);
    check("rst pready", 32'(bus.pready), 32'h1);
    check("rst irq", 32'(irq), 32'h0);
    bus.paddr = 32'h140;
    @(negedge pclk);
    check("rst pslverr unmapped", 32'(bus.pslverr), 32'h0);
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    hrst = 1'b0;
    repeat (6) @(posedge pclk);
    #1;
    check("post-rst irq", 32'(irq), 32'h0);
    rd_check("post-rst int_en", 32'h004, 32'h0);
    rd_check("post-rst int_stat", 32'h008, 32'h0);
    rd_check("post-rst ctrl0", 32'h100, 32'h0);
    rd_check("post-rst load0", 32'h104, 32'h0);
    rd_check("post-rst count0", 32'h108, 32'h0);
    rd_check("post-rst count2", 32'h128, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
